// File: rtl/mips_mem_responder.sv
// mips_mem_responder
//   Word-addressed unified instruction/data memory for the multicycle MIPS
//   controller. It answers MemRead/MemWrite strobes after a configurable number
//   of wait states. Completion is signalled by a one-cycle ready pulse.
//   Malformed requests are signalled by a one-cycle err pulse.
//
// Parameters
//   ADDR_W   word-address bits; depth = 2**ADDR_W 32-bit words
//   LATENCY  cycles spent in WAIT before the access commits (1..15)
//
// Ports
//   cclk       in   clock, rising edge
//   rstb       in   synchronous active-low reset
//   mem_read   in   read request
//   mem_write  in   write request
//   addr       in   byte address; word index = addr[ADDR_W+1:2]
//   wdata      in   write data
//   rdata      out  registered read data; holds the last completed read
//   ready      out  one-cycle pulse: access complete
//   busy       out  high in WAIT and RESP; requests ignored while high
//   err        out  one-cycle pulse: request rejected, no access performed
//
// Configuration
//   MEM_ALIGN_CHECK_EN  when defined, an IDLE request with addr[1:0] != 0 is
//                       rejected through the same err path as a request with
//                       both strobes high.
module mips_mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        cclk,
    input  logic        rstb,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] COUNT_INIT = 4'(LATENCY - 1);

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("mips_mem_responder: LATENCY must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        count;
    logic [3:0]        count_nxt;
    logic              op_write;
    logic              op_write_nxt;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_nxt;
    logic [31:0]       wbuf;
    logic [31:0]       wbuf_nxt;
    logic              err_nxt;
    logic              mem_we;
    logic              rdata_ld;
    logic              misaligned;
    logic              accept;
    logic              reject;

    logic [31:0]       mem [DEPTH];

    // Address bits above the word index alias onto the same word.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:ADDR_W+2], addr[1:0]};

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = (addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // Both strobes high wins over the alignment check; both reject the same way.
    assign accept = mem_read ^ mem_write;
    assign reject = (mem_read & mem_write) | (accept & misaligned);

    always_comb begin
        state_nxt    = state;
        count_nxt    = count;
        op_write_nxt = op_write;
        idx_nxt      = idx;
        wbuf_nxt     = wbuf;
        err_nxt      = 1'b0;
        mem_we       = 1'b0;
        rdata_ld     = 1'b0;
        ready        = 1'b0;
        busy         = 1'b0;

        case (state)
            ST_IDLE: begin
                if (reject) begin
                    err_nxt = 1'b1;
                end else if (accept) begin
                    op_write_nxt = mem_write;
                    idx_nxt      = addr[ADDR_W+1:2];
                    wbuf_nxt     = wdata;
                    count_nxt    = COUNT_INIT;
                    state_nxt    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (count != 4'd0) begin
                    count_nxt = count - 4'd1;
                end else begin
                    mem_we    = op_write;
                    rdata_ld  = ~op_write;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                busy      = 1'b1;
                ready     = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge cclk) begin
        if (!rstb) begin
            state    <= ST_IDLE;
            count    <= '0;
            op_write <= 1'b0;
            idx      <= '0;
            wbuf     <= '0;
            err      <= 1'b0;
            rdata    <= '0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            op_write <= op_write_nxt;
            idx      <= idx_nxt;
            wbuf     <= wbuf_nxt;
            err      <= err_nxt;
            if (rdata_ld) begin
                rdata <= mem[idx];
            end
        end
    end

    // The array has no reset. The rstb gate keeps a reset on the commit edge
    // from writing a request that is being aborted.
    always_ff @(posedge cclk) begin
        if (rstb && mem_we) begin
            mem[idx] <= wbuf;
        end
    end

endmodule

// File: tb/tb_mips_mem_responder.sv
module tb_mips_mem_responder;

    localparam int ADDR_W  = 8;
    localparam int LATENCY = 2;

    logic        cclk;
    logic        rstb;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;
    logic        err;

    int passed;
    int total;

    logic [31:0] exp_q[$];
    logic [31:0] model_mem [256];
    logic [31:0] last_read;

    mips_mem_responder #(
        .ADDR_W (ADDR_W),
        .LATENCY(LATENCY)
    ) dut (
        .cclk     (cclk),
        .rstb     (rstb),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .ready    (ready),
        .busy     (busy),
        .err      (err)
    );

    initial cclk = 1'b0;
    always #5 cclk = ~cclk;

    // Drives one request and waits (bounded) for ready. lat is the number of
    // edges after the accept edge until ready is seen, or -1 on timeout.
    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] rd,
                         output logic busy_acc, output logic ready_next);
        mem_write = wr;
        mem_read  = ~wr;
        addr      = a;
        wdata     = d;
        if (wr) model_mem[a[9:2]] = d;
        @(posedge cclk); #1;
        busy_acc = busy;
        lat = 0;
        while (ready !== 1'b1 && lat < 40) begin
            @(posedge cclk); #1;
            lat++;
        end
        if (ready !== 1'b1) lat = -1;
        rd = rdata;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge cclk); #1;
        ready_next = ready;
    endtask

    task automatic test_reset();
        rstb = 1'b0; mem_read = 1'b1; mem_write = 1'b1; addr = '1; wdata = '1;
        repeat (2) begin @(posedge cclk); #1; end
        total++; if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h expected %h", rdata, 32'h0); else passed++;
        total++; if (ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", ready); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
        total++; if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err); else passed++;
        rstb = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
        @(posedge cclk); #1;
    endtask

    task automatic test_write_read();
        int lat; logic [31:0] rd; logic b; logic rn; logic [31:0] e;
        issue(1'b1, 32'h10, 32'hDEADBEEF, lat, rd, b, rn);
        total++; if (lat != LATENCY) $display("FAIL wr_latency: got %0d expected %0d", lat, LATENCY); else passed++;
        total++; if (b !== 1'b1) $display("FAIL wr_busy: got %b expected 1", b); else passed++;
        total++; if (rn !== 1'b0) $display("FAIL wr_ready_width: got %b expected 0", rn); else passed++;
        exp_q.push_back(32'hDEADBEEF);
        issue(1'b0, 32'h10, 32'h0, lat, rd, b, rn);
        e = exp_q.pop_front();
        total++; if (lat != LATENCY) $display("FAIL rd_latency: got %0d expected %0d", lat, LATENCY); else passed++;
        total++; if (rn !== 1'b0) $display("FAIL rd_ready_width: got %b expected 0", rn); else passed++;
        total++; if (rd !== e) $display("FAIL rd_data: got %h expected %h", rd, e); else passed++;
    endtask

    task automatic test_wrap();
        int lat; logic [31:0] rd; logic b; logic rn; logic [31:0] e;
        issue(1'b1, 32'h400, 32'h12345678, lat, rd, b, rn);
        exp_q.push_back(32'h12345678);
        issue(1'b0, 32'h0, 32'h0, lat, rd, b, rn);
        e = exp_q.pop_front();
        total++; if (lat != LATENCY) $display("FAIL wrap_latency: got %0d expected %0d", lat, LATENCY); else passed++;
        total++; if (rd !== e) $display("FAIL wrap_data: got %h expected %h", rd, e); else passed++;
        last_read = e;
    endtask

    task automatic test_both_strobes();
        logic ready_seen;
        mem_read = 1'b1; mem_write = 1'b1; addr = 32'h10; wdata = 32'h0BAD0BAD;
        @(posedge cclk); #1;
        total++; if (err !== 1'b1) $display("FAIL both_err: got %b expected 1", err); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL both_busy: got %b expected 0", busy); else passed++;
        ready_seen = ready;
        mem_read = 1'b0; mem_write = 1'b0;
        repeat (4) begin
            @(posedge cclk); #1;
            ready_seen = ready_seen | ready;
        end
        total++; if (err !== 1'b0) $display("FAIL both_err_width: got %b expected 0", err); else passed++;
        total++; if (ready_seen !== 1'b0) $display("FAIL both_ready: got %b expected 0", ready_seen); else passed++;
        total++; if (rdata !== last_read) $display("FAIL both_rdata: got %h expected %h", rdata, last_read); else passed++;
    endtask

    task automatic test_reset_in_wait();
        int lat; logic [31:0] rd; logic b; logic rn; logic [31:0] e;
        issue(1'b1, 32'h20, 32'h0, lat, rd, b, rn);
        mem_write = 1'b1; mem_read = 1'b0; addr = 32'h20; wdata = 32'hA5A5A5A5;
        @(posedge cclk); #1;
        total++; if (busy !== 1'b1) $display("FAIL rstwait_busy: got %b expected 1", busy); else passed++;
        rstb = 1'b0;
        @(posedge cclk); #1;
        total++; if (busy !== 1'b0) $display("FAIL rstwait_idle: got busy %b expected 0", busy); else passed++;
        total++; if (ready !== 1'b0) $display("FAIL rstwait_ready: got %b expected 0", ready); else passed++;
        rstb = 1'b1; mem_write = 1'b0;
        repeat (3) begin @(posedge cclk); #1; end
        total++; if (ready !== 1'b0) $display("FAIL rstwait_late_ready: got %b expected 0", ready); else passed++;
        exp_q.push_back(model_mem[8'h08]);
        issue(1'b0, 32'h20, 32'h0, lat, rd, b, rn);
        e = exp_q.pop_front();
        total++; if (lat != LATENCY) $display("FAIL rstwait_rd_latency: got %0d expected %0d", lat, LATENCY); else passed++;
        total++; if (rd !== e) $display("FAIL rstwait_rd_data: got %h expected %h", rd, e); else passed++;
        last_read = e;
    endtask

    task automatic test_misaligned();
`ifdef MEM_ALIGN_CHECK_EN
        logic ready_seen;
        mem_read = 1'b1; mem_write = 1'b0; addr = 32'h13;
        @(posedge cclk); #1;
        total++; if (err !== 1'b1) $display("FAIL mis_err: got %b expected 1", err); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL mis_busy: got %b expected 0", busy); else passed++;
        ready_seen = ready;
        mem_read = 1'b0;
        repeat (4) begin
            @(posedge cclk); #1;
            ready_seen = ready_seen | ready;
        end
        total++; if (ready_seen !== 1'b0) $display("FAIL mis_ready: got %b expected 0", ready_seen); else passed++;
        total++; if (rdata !== last_read) $display("FAIL mis_rdata: got %h expected %h", rdata, last_read); else passed++;
`else
        int lat; logic [31:0] rd; logic b; logic rn; logic [31:0] e;
        exp_q.push_back(model_mem[8'h04]);
        issue(1'b0, 32'h13, 32'h0, lat, rd, b, rn);
        e = exp_q.pop_front();
        total++; if (lat != LATENCY) $display("FAIL mis_latency: got %0d expected %0d", lat, LATENCY); else passed++;
        total++; if (rd !== e) $display("FAIL mis_data: got %h expected %h", rd, e); else passed++;
        last_read = e;
`endif
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] rd; logic b; logic rn; logic [31:0] e;
        logic [31:0] a;
        int bad_lat;
        bad_lat = 0;
        for (int i = 0; i < 8; i++) begin
            a = ($urandom & 32'hFFFF_FC00) | (32'(64 + i * 3) << 2);
            issue(1'b1, a, $urandom, lat, rd, b, rn);
            if (lat != LATENCY) bad_lat++;
        end
        for (int i = 0; i < 8; i++) begin
            a = ($urandom & 32'hFFFF_FC00) | (32'(64 + i * 3) << 2);
            exp_q.push_back(model_mem[a[9:2]]);
            issue(1'b0, a, 32'h0, lat, rd, b, rn);
            if (lat != LATENCY) bad_lat++;
            e = exp_q.pop_front();
            total++; if (rd !== e) $display("FAIL b2b_data[%0d]: got %h expected %h", i, rd, e); else passed++;
        end
        total++; if (bad_lat != 0) $display("FAIL b2b_latency: got %0d late accesses expected 0", bad_lat); else passed++;
        total++; if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size()); else passed++;
    endtask

    initial begin
        passed = 0; total = 0; last_read = '0;
        rstb = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
        foreach (model_mem[i]) model_mem[i] = '0;
        @(posedge cclk); #1;
        test_reset();
        test_write_read();
        test_wrap();
        test_both_strobes();
        test_reset_in_wait();
        test_misaligned();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
